// File: rtl/set_cfg_bank.sv
// Slow-peripheral configuration bank written through the SET chip-select, with optional
// arm-key gating of commits and a slow-access timeout down-counter for the bus controller.
module set_cfg_bank #(
    parameter int              NUM_DEV  = 7,
    parameter int              TO_W     = 4,
    parameter logic [TO_W-1:0] TO_RESET = '1,
    parameter bit              LOCK     = 1'b0,
    parameter int unsigned     ARM_KEY  = 0,
    parameter int              ARM_WIN  = 8
) (
    input  logic                  CLK,
    input  logic                  POR,
    input  logic                  BACT,
    input  logic [NUM_DEV+TO_W:1] A,
    input  logic                  SetCSWR,
    input  logic                  TimerStart,
    input  logic                  TimerAbort,
    output logic [NUM_DEV-1:0]    SlowDev,
    output logic [TO_W-1:0]       SlowTimeout,
    output logic                  CfgUpdate,
    output logic                  Armed,
    output logic                  TimerBusy,
    output logic                  TimerExpire
);
    localparam int A_W  = NUM_DEV + TO_W;
    localparam int AC_W = (ARM_WIN > 1) ? $clog2(ARM_WIN) : 1;
    localparam logic [A_W:1] KEY = A_W'(ARM_KEY);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AC_W-1:0]   armcnt_q, armcnt_d;
    logic              wr_q, wr2_q;
    logic [A_W:1]      ar_q;
    logic [NUM_DEV-1:0] slowdev_q, slowdev_d;
    logic [TO_W-1:0]   slowto_q, slowto_d;
    logic              cfgupd_q, cfgupd_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              expire_q, expire_d;
    logic              access;
    logic              commit;

    // A long strobe produces exactly one access on its first registered cycle.
    assign access = wr_q && !wr2_q;

    always_comb begin
        state_d  = state_q;
        armcnt_d = armcnt_q;
        commit   = 1'b0;
        if (!LOCK) begin
            commit = access;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access && ar_q == KEY) begin
                        state_d  = S_ARMED;
                        armcnt_d = AC_W'(ARM_WIN - 1);
                    end
                end
                S_ARMED: begin
                    if (access) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end else if (armcnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        armcnt_d = armcnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        slowdev_d = slowdev_q;
        slowto_d  = slowto_q;
        cfgupd_d  = commit;
        if (commit) begin
            slowdev_d = ar_q[NUM_DEV:1];
            slowto_d  = ar_q[A_W:NUM_DEV+1];
        end
    end

    // Abort beats Start beats expiry; Start reloads from the previously committed timeout.
    always_comb begin
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        expire_d = 1'b0;
        if (TimerAbort) begin
            busy_d = 1'b0;
        end else if (TimerStart) begin
            cnt_d  = slowto_q;
            busy_d = 1'b1;
        end else if (busy_q && cnt_q == '0) begin
            busy_d   = 1'b0;
            expire_d = 1'b1;
        end else if (busy_q) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (POR) begin
            wr_q      <= 1'b0;
            wr2_q     <= 1'b0;
            state_q   <= S_IDLE;
            armcnt_q  <= '0;
            slowdev_q <= '0;
            slowto_q  <= TO_RESET;
            cfgupd_q  <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            expire_q  <= 1'b0;
        end else begin
            wr_q      <= BACT && SetCSWR;
            wr2_q     <= wr_q;
            state_q   <= state_d;
            armcnt_q  <= armcnt_d;
            slowdev_q <= slowdev_d;
            slowto_q  <= slowto_d;
            cfgupd_q  <= cfgupd_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            expire_q  <= expire_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (BACT && SetCSWR) begin
            ar_q <= A;
        end
    end

    assign SlowDev     = slowdev_q;
    assign SlowTimeout = slowto_q;
    assign CfgUpdate   = cfgupd_q;
    assign Armed       = (state_q == S_ARMED);
    assign TimerBusy   = busy_q;
    assign TimerExpire = expire_q;

endmodule

// File: tb/tb_set_cfg_bank.sv
// Directed bench: an unlocked (u0) and an arm-key locked (u1) bank share one stimulus stream.
module tb_set_cfg_bank;
    logic        CLK = 1'b0;
    logic        POR, BACT, SetCSWR, TimerStart, TimerAbort;
    logic [11:1] A;
    logic [6:0]  sd0, sd1;
    logic [3:0]  to0, to1;
    logic        cu0, cu1, ar0, ar1, tb0, tb1, te0, te1;
    int          checks = 0;
    int          errors = 0;
    int          pulses0, pulses1;

    always #5 CLK = ~CLK;

    set_cfg_bank #(.LOCK(1'b0)) u0 (
        .CLK(CLK), .POR(POR), .BACT(BACT), .A(A), .SetCSWR(SetCSWR),
        .TimerStart(TimerStart), .TimerAbort(TimerAbort),
        .SlowDev(sd0), .SlowTimeout(to0), .CfgUpdate(cu0), .Armed(ar0),
        .TimerBusy(tb0), .TimerExpire(te0)
    );

    set_cfg_bank #(.LOCK(1'b1), .ARM_KEY(0), .ARM_WIN(8)) u1 (
        .CLK(CLK), .POR(POR), .BACT(BACT), .A(A), .SetCSWR(SetCSWR),
        .TimerStart(TimerStart), .TimerAbort(TimerAbort),
        .SlowDev(sd1), .SlowTimeout(to1), .CfgUpdate(cu1), .Armed(ar1),
        .TimerBusy(tb1), .TimerExpire(te1)
    );

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns at the negedge after the commit edge.
    task automatic write_a(input logic [11:1] v);
        BACT = 1'b1; SetCSWR = 1'b1; A = v;
        tick();
        BACT = 1'b0; SetCSWR = 1'b0;
        tick();
    endtask

    initial begin
        POR = 1'b1; BACT = 1'b0; SetCSWR = 1'b0; TimerStart = 1'b0; TimerAbort = 1'b0; A = '0;
        tick(); tick();
        chk("rst_sd0", sd0, 7'h00);
        chk("rst_to0", to0, 4'hF);
        chk("rst_cu0", cu0, 1'b0);
        chk("rst_tb0", tb0, 1'b0);
        chk("rst_te0", te0, 1'b0);
        chk("rst_ar1", ar1, 1'b0);
        chk("rst_sd1", sd1, 7'h00);
        chk("rst_to1", to1, 4'hF);
        POR = 1'b0;
        tick();

        // byte address 0x5A6 -> A[11:1] = 0x2D3: flags 0x53, timeout 5
        BACT = 1'b1; SetCSWR = 1'b1; A = 11'h2D3;
        tick();
        BACT = 1'b0; SetCSWR = 1'b0;
        chk("lat_to0", to0, 4'hF);
        chk("lat_cu0", cu0, 1'b0);
        tick();
        chk("w1_sd0", sd0, 7'h53);
        chk("w1_to0", to0, 4'h5);
        chk("w1_cu0", cu0, 1'b1);
        chk("nokey_sd1", sd1, 7'h00);
        chk("nokey_to1", to1, 4'hF);
        chk("nokey_cu1", cu1, 1'b0);
        chk("nokey_ar1", ar1, 1'b0);
        tick();
        chk("w1_cu0_end", cu0, 1'b0);

        // strobe held 10 cycles, address changes after the first cycle
        pulses0 = 0; pulses1 = 0;
        BACT = 1'b1; SetCSWR = 1'b1; A = 11'h155;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) A = 11'h7FF;
            pulses0 += int'(cu0);
            pulses1 += int'(cu1);
        end
        BACT = 1'b0; SetCSWR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses0 += int'(cu0);
            pulses1 += int'(cu1);
        end
        chk("hold_pulses0", pulses0, 1);
        chk("hold_sd0", sd0, 7'h55);
        chk("hold_to0", to0, 4'h2);
        chk("hold_pulses1", pulses1, 0);

        // arm with key, commit inside window
        write_a(11'h000);
        chk("arm_ar1", ar1, 1'b1);
        chk("arm_cu1", cu1, 1'b0);
        chk("arm_ar0", ar0, 1'b0);
        tick();
        write_a(11'h7FF);
        chk("cmt_sd1", sd1, 7'h7F);
        chk("cmt_to1", to1, 4'hF);
        chk("cmt_cu1", cu1, 1'b1);
        chk("cmt_ar1", ar1, 1'b0);

        // arm then let the window lapse
        write_a(11'h000);
        chk("win_ar1_0", ar1, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("win_ar1_hold", ar1, 1'b1);
        end
        tick();
        chk("win_ar1_drop", ar1, 1'b0);
        write_a(11'h123);
        chk("late_sd1", sd1, 7'h7F);
        chk("late_to1", to1, 4'hF);
        chk("late_cu1", cu1, 1'b0);

        // reset while armed
        write_a(11'h000);
        chk("por_pre_ar1", ar1, 1'b1);
        POR = 1'b1;
        tick();
        POR = 1'b0;
        chk("por_ar1", ar1, 1'b0);
        chk("por_sd1", sd1, 7'h00);
        chk("por_to1", to1, 4'hF);
        chk("por_to0", to0, 4'hF);

        // timer with timeout 3
        write_a(11'h180);
        chk("t3_to0", to0, 4'h3);
        TimerStart = 1'b1;
        tick();
        TimerStart = 1'b0;
        chk("t3_busy", tb0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t3_exp", te0, (i == 4) ? 1'b1 : 1'b0);
            chk("t3_busy_seq", tb0, (i < 4) ? 1'b1 : 1'b0);
        end

        // restart at count 0 reloads without expiring
        TimerStart = 1'b1;
        tick();
        TimerStart = 1'b0;
        tick(); tick(); tick();
        TimerStart = 1'b1;
        tick();
        TimerStart = 1'b0;
        chk("rs_exp", te0, 1'b0);
        chk("rs_busy", tb0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("rs_exp_seq", te0, (i == 4) ? 1'b1 : 1'b0);
        end

        // start and abort together
        TimerStart = 1'b1; TimerAbort = 1'b1;
        tick();
        TimerStart = 1'b0; TimerAbort = 1'b0;
        chk("sa_busy", tb0, 1'b0);
        chk("sa_exp", te0, 1'b0);
        tick();
        chk("sa_exp2", te0, 1'b0);

        // timeout 0 expires one cycle after start
        write_a(11'h000);
        chk("t0_to0", to0, 4'h0);
        TimerStart = 1'b1;
        tick();
        TimerStart = 1'b0;
        chk("t0_busy", tb0, 1'b1);
        tick();
        chk("t0_exp", te0, 1'b1);
        chk("t0_busy_end", tb0, 1'b0);

        // reset mid-count
        write_a(11'h180);
        TimerStart = 1'b1;
        tick();
        TimerStart = 1'b0;
        tick();
        POR = 1'b1;
        tick();
        POR = 1'b0;
        chk("rmc_busy", tb0, 1'b0);
        pulses0 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses0 += int'(te0);
        end
        chk("rmc_exp", pulses0, 0);
        chk("rmc_to0", to0, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
